seven_seg_scan: RTL

- Time-multiplexed scan controller for an NDIG-digit, common-anode 7-segment display.
- Sits directly upstream of the hex 7-segment decoder:
  - drives its 4-bit digit input and its dot enable;
  - drives the low-active digit (anode) selects itself.
- Holds a frame-consistent copy of the display value, so a mid-scan update never tears the display.
- Inserts an anti-ghosting guard at the start of every digit slot.

---
 rtl/seven_seg_scan.sv | 121 ++++++++++++
 1 files changed

// File: rtl/seven_seg_scan.sv
// Multiplexed common-anode 7-segment scan driver with frame-consistent data and anti-ghost guard.
// Optional leading-zero blanking when SEVEN_SCAN_LZB_EN is defined.
module seven_seg_scan #(
  parameter int NDIG  = 4,
  parameter int DW    = 4,
  parameter int DIV   = 50000,
  parameter int GUARD = 500
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NDIG*DW-1:0] din,
  input  logic [NDIG-1:0]    dot_in,
  input  logic               load,
  output logic [DW-1:0]      dig_out,
  output logic               dot_en,
  output logic [NDIG-1:0]    an_n,
  output logic               frame_start
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

  logic [CW-1:0]      cnt;
  logic [IW-1:0]      idx;
  logic [NDIG*DW-1:0] pend_d;
  logic [NDIG*DW-1:0] act_d;
  logic [NDIG-1:0]    pend_dot;
  logic [NDIG-1:0]    act_dot;
  logic               pend_flag;

  logic               wrap;
  logic               boundary;
  logic               in_guard;
  logic               blank;
  logic [DW-1:0]      cur_dig;
  logic               cur_dot;
  logic [NDIG-1:0]    sel_n;

  assign wrap     = (cnt == CNT_LAST);
  assign boundary = wrap && (idx == IDX_LAST);

  generate
    if (GUARD > 0) begin : g_guard
      assign in_guard = (cnt < CW'(GUARD));
    end else begin : g_noguard
      assign in_guard = 1'b0;
    end
  endgenerate

  always_comb begin
    cur_dig = '0;
    cur_dot = 1'b0;
    sel_n   = '1;
    for (int k = 0; k < NDIG; k++) begin
      if (idx == IW'(k)) begin
        cur_dig  = act_d[k*DW +: DW];
        cur_dot  = act_dot[k];
        sel_n[k] = 1'b0;
      end
    end
  end

`ifdef SEVEN_SCAN_LZB_EN
  // run tracks "everything from the top digit down to k is blank"
  logic run;
  always_comb begin
    run   = 1'b1;
    blank = 1'b0;
    for (int k = NDIG - 1; k >= 1; k--) begin
      run = run && (act_d[k*DW +: DW] == '0) && !act_dot[k];
      if (idx == IW'(k)) blank = run;
    end
  end
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      idx         <= '0;
      pend_d      <= '0;
      pend_dot    <= '0;
      act_d       <= '0;
      act_dot     <= '0;
      pend_flag   <= 1'b0;
      dig_out     <= '0;
      dot_en      <= 1'b0;
      an_n        <= '1;
      frame_start <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + CW'(1);
      if (wrap) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end

      if (boundary) begin
        if (load) begin
          act_d   <= din;
          act_dot <= dot_in;
        end else if (pend_flag) begin
          act_d   <= pend_d;
          act_dot <= pend_dot;
        end
        pend_flag <= 1'b0;
      end else if (load) begin
        pend_d    <= din;
        pend_dot  <= dot_in;
        pend_flag <= 1'b1;
      end

      dig_out     <= cur_dig;
      dot_en      <= cur_dot;
      an_n        <= (in_guard || blank) ? '1 : sel_n;
      frame_start <= (idx == '0) && (cnt == '0);
    end
  end

endmodule
